// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder controller. Sequences a single one-bit full
//            adder LSB-first over WIDTH cycles to compute A + B + cin, and
//            owns the operand shift registers, carry flop, bit counter,
//            start/busy/done handshake and the registered result.
// Ports    : clk      - clock, all state changes on its rising edge
//            rst_n    - asynchronous active-low reset
//            start_i  - job request, only looked at in IDLE
//            a_i/b_i  - operands, captured on the accepting edge
//            cin_i    - carry-in, captured on the accepting edge
//            busy_o   - high while the job is being shifted through (RUN)
//            done_o   - one-cycle pulse, result valid (DONE)
//            sum_o    - A + B + cin mod 2**WIDTH, held until the next DONE
//            cout_o   - carry out of bit WIDTH-1
//            ovf_o    - signed overflow (carry into MSB xor carry out)
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    // Holds the WIDTH-1 result bits produced so far; the final bit is
    // appended straight into sum_q on the last RUN edge.
    logic [WIDTH-2:0] acc_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Shared one-bit full adder.
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] acc_d;

    assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) |
                      (b_sr_q[0] & carry_q);
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign acc_d    = {fa_sum, acc_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sr_q  <= a_i;
                        b_sr_q  <= b_i;
                        carry_q <= cin_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d[WIDTH-1:1];
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= fa_carry;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // carry_q here is the carry into the MSB.
                        sum_q   <= acc_d;
                        cout_q  <= fa_carry;
                        ovf_q   <= carry_q ^ fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire
